uart_rx_deserializer: RTL

Serial-to-parallel receive engine for the UART transceiver. It sits directly downstream of the `uart_rxd` pad (`uio_in[2]`) and drives the transceiver's `rx_leds`, `uart_rx_valid` and `uart_rx_break` outputs. It recovers 8N1 frames using a mid-bit sampling counter and delivers each byte with a one-cycle valid strobe. It also reports BREAK conditions and framing errors.

---
 rtl/uart_rx_deserializer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receive engine: 2-flop input synchronizer, mid-bit sampling FSM,
// one-cycle valid / break / framing-error strobes.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 1042,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    uart_rxd,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_break,
  output logic                    uart_rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int IDX_W = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_e;

  logic                    rxd_meta_q;
  logic                    rxd_sync_q;
  logic                    rxd_s;

  state_e                  state_q,  state_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic [IDX_W-1:0]        idx_q,    idx_d;
  logic [PAYLOAD_BITS-1:0] shift_q,  shift_d;
  logic [PAYLOAD_BITS-1:0] data_q,   data_d;
  logic                    valid_q,  valid_d;
  logic                    break_q,  break_d;
  logic                    ferr_q,   ferr_d;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  assign rxd_s = rxd_sync_q;

  // Next-state and strobe decode for the receive FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    break_d = 1'b0;
    ferr_d  = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      shift_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = '0;
          if (!rxd_s) begin
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end

        // Start bit must still be low at its midpoint, otherwise it was a glitch.
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d = '0;
            if (rxd_s) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d                   = '0;
            shift_d                 = shift_q >> 1;
            shift_d[PAYLOAD_BITS-1] = rxd_s;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              state_d = S_STOP;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        // A low stop bit with all-zero data is a BREAK, otherwise a framing error.
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d = '0;
            if (rxd_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else if (shift_q == '0) begin
              break_d = 1'b1;
              state_d = S_WAIT_HIGH;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_WAIT_HIGH;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_WAIT_HIGH: begin
          cnt_d = '0;
          idx_d = '0;
          if (rxd_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_HIGH;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = '0;
        end
      endcase
    end
  end

  // Receive FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      break_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      break_q <= break_d;
      ferr_q  <= ferr_d;
    end
  end

  assign uart_rx_data      = data_q;
  assign uart_rx_valid     = valid_q;
  assign uart_rx_break     = break_q;
  assign uart_rx_frame_err = ferr_q;

endmodule
